// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and helpers for the instruction-fetch responder.
package inst_mem_responder_pkg;

    // Default byte-address width of the fetch PC (RAM holds 2**(ADDR_W-2) words).
    localparam int unsigned InstCatchDepth = 10;

    // Default instruction width.
    localparam int unsigned DefaultDataW = 32;

    // Default response buffer depth.
    localparam int unsigned DefaultFifoDepth = 2;

    // Instruction returned for misaligned fetches (addi x0, x0, 0).
    localparam logic [31:0] InstNop = 32'h0000_0013;

    // A fetch is misaligned when the byte PC is not word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rsp_fifo.sv
// Small synchronous FIFO holding fetch responses that the consumer could not take yet.
// Entries are opaque packed words; flush empties the FIFO and wins over push/pop.
module inst_rsp_fifo #(
    parameter int unsigned  WIDTH = 1,
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign dout  = slot_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                slot_d[wr_ptr_q] = din;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The credit logic upstream must never push into a full FIFO without a pop.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !(pop && !empty)));

    // Pops are only issued while an entry is present.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && empty));

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: synchronous-read instruction RAM with a one-cycle fetch
// pipeline, a small response buffer for backpressure, jump flush and a loader write port.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = InstCatchDepth,
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned IdxW   = ADDR_W - 2;
    localparam int unsigned Words  = 2 ** IdxW;
    localparam int unsigned EntryW = 1 + ADDR_W + DATA_W;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

    // Instruction storage; contents survive reset.
    logic [DATA_W-1:0] mem [Words];

    // Stage-1: the word read in the cycle after acceptance.
    logic              s1_valid_q, s1_valid_d;
    logic              s1_err_q, s1_err_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_inst_q, s1_inst_d;
    logic [EntryW-1:0] s1_entry;

    logic              accept;
    logic [CntW:0]     occ;

    logic              fifo_push;
    logic              fifo_pop;
    logic [EntryW-1:0] fifo_head;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    // Loader address bits below the word boundary carry no information.
    logic              unused_wr_lsb;
    logic              unused_fifo_full;
    assign unused_wr_lsb    = ^wr_addr[1:0];
    assign unused_fifo_full = fifo_full;

    // Loader write port; the fetch read below sees the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[ADDR_W-1:2]] <= wr_data;
        end
    end

    // Credit check: occupancy counts buffered entries plus the word in stage-1.
    // A flushing cycle frees every credit, so the new-path fetch is always taken.
    always_comb begin
        occ       = {1'b0, fifo_count} + (CntW + 1)'(s1_valid_q);
        req_ready = flush | (occ < (CntW + 1)'(FIFO_DEPTH));
        accept    = req_valid & req_ready;
    end

    // Stage-1 next state: capture RAM word, PC and alignment on acceptance.
    always_comb begin
        s1_valid_d = accept;
        s1_err_d   = s1_err_q;
        s1_addr_d  = s1_addr_q;
        s1_inst_d  = s1_inst_q;
        if (accept) begin
            s1_err_d  = is_misaligned(req_addr[1:0]);
            s1_addr_d = req_addr;
            s1_inst_d = mem[req_addr[ADDR_W-1:2]];
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_inst_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_addr_q  <= s1_addr_d;
            s1_inst_q  <= s1_inst_d;
        end
    end

    // Response mux and buffer control: the FIFO head has priority to keep order;
    // an unconsumed stage-1 word falls into the FIFO behind it.
    always_comb begin
        s1_entry  = {s1_err_q, s1_addr_q, s1_err_q ? DATA_W'(InstNop) : s1_inst_q};
        fifo_pop  = ~fifo_empty & rsp_ready & ~flush;
        fifo_push = s1_valid_q & ~flush & ~(fifo_empty & rsp_ready);
        rsp_valid = ~fifo_empty | s1_valid_q;
        if (fifo_empty) begin
            {rsp_err, rsp_addr, rsp_inst} = s1_entry;
        end else begin
            {rsp_err, rsp_addr, rsp_inst} = fifo_head;
        end
    end

    inst_rsp_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (s1_entry),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: streaming, backpressure, flush, misaligned
// fetch, read-first write collision, top-of-memory fetch and mid-run reset.
module tb_inst_mem_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr  = '0;
    logic          flush     = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_inst;
    logic [AW-1:0] rsp_addr;
    logic          rsp_err;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_mem_responder #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns just after the edge with outputs settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input string tag, input logic [AW-1:0] addr,
                              input logic [DW-1:0] inst, input logic err);
        check_val({tag, "_valid"}, 64'(rsp_valid), 64'(1));
        check_val({tag, "_addr"},  64'(rsp_addr),  64'(addr));
        check_val({tag, "_inst"},  64'(rsp_inst),  64'(inst));
        check_val({tag, "_err"},   64'(rsp_err),   64'(err));
    endtask

    task automatic load_word(input int idx, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(idx * 4);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #2;
        check_val("rst_valid", 64'(rsp_valid), 64'(0));
        check_val("rst_ready", 64'(req_ready), 64'(1));
        check_val("rst_inst",  64'(rsp_inst),  64'(0));
        check_val("rst_addr",  64'(rsp_addr),  64'(0));
        check_val("rst_err",   64'(rsp_err),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            load_word(i, 32'h1000_0000 + 32'(i));
        end
        load_word(255, 32'hCAFE_F00D);

        // 1: back-to-back fetches with no backpressure, one-cycle latency.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(i * 4);
            #1;
            check_val($sformatf("t1_ready%0d", i), 64'(req_ready), 64'(1));
            tick();
            expect_rsp($sformatf("t1_rsp%0d", i), AW'(i * 4), 32'h1000_0000 + 32'(i), 1'b0);
        end
        req_valid = 1'b0;
        tick();
        check_val("t1_drain", 64'(rsp_valid), 64'(0));

        // 2: backpressure; only two requests accepted, then in-order release.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 'h00;
        tick();
        check_val("t2_ready_a", 64'(req_ready), 64'(1));
        check_val("t2_addr_a",  64'(rsp_addr),  64'(0));
        req_addr = 'h04;
        tick();
        check_val("t2_ready_b", 64'(req_ready), 64'(0));
        req_addr = 'h08;
        tick();
        check_val("t2_ready_c", 64'(req_ready), 64'(0));
        expect_rsp("t2_hold", 'h00, 32'h1000_0000, 1'b0);
        tick();
        check_val("t2_ready_d", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        tick();
        expect_rsp("t2_rsp1", 'h04, 32'h1000_0001, 1'b0);
        check_val("t2_ready_e", 64'(req_ready), 64'(1));
        tick();
        expect_rsp("t2_rsp2", 'h08, 32'h1000_0002, 1'b0);
        req_valid = 1'b0;
        tick();
        check_val("t2_drain", 64'(rsp_valid), 64'(0));

        // 3: flush with two buffered responses; new-path fetch in the flush cycle is kept.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 'h00;
        tick();
        req_addr = 'h04;
        tick();
        req_valid = 1'b0;
        tick();
        check_val("t3_full_ready", 64'(req_ready), 64'(0));
        check_val("t3_full_addr",  64'(rsp_addr),  64'(0));
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 'h40;
        #1;
        check_val("t3_flush_ready", 64'(req_ready), 64'(1));
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        expect_rsp("t3_newpath", 'h40, 32'h1000_0010, 1'b0);
        rsp_ready = 1'b1;
        tick();
        check_val("t3_no_stale", 64'(rsp_valid), 64'(0));

        // 4: misaligned fetch returns NOP with the error flag and original PC.
        req_valid = 1'b1;
        req_addr  = 'h06;
        tick();
        req_valid = 1'b0;
        expect_rsp("t4_misal", 'h06, 32'h0000_0013, 1'b1);
        tick();

        // 5: write and fetch of the same word in one cycle returns the old word.
        wr_en     = 1'b1;
        wr_addr   = 'h0C;
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 'h0C;
        tick();
        wr_en = 1'b0;
        expect_rsp("t5_old", 'h0C, 32'h1000_0003, 1'b0);
        tick();
        req_valid = 1'b0;
        expect_rsp("t5_new", 'h0C, 32'hDEAD_BEEF, 1'b0);
        tick();

        // Last word of the address space.
        req_valid = 1'b1;
        req_addr  = 'h3FC;
        tick();
        req_valid = 1'b0;
        expect_rsp("top_word", 'h3FC, 32'hCAFE_F00D, 1'b0);
        tick();

        // 6: asynchronous reset with the response path fully occupied.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 'h10;
        tick();
        req_addr = 'h14;
        tick();
        req_valid = 1'b0;
        check_val("t6_busy_valid", 64'(rsp_valid), 64'(1));
        check_val("t6_busy_ready", 64'(req_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(rsp_valid), 64'(0));
        check_val("t6_rst_ready", 64'(req_ready), 64'(1));
        check_val("t6_rst_addr",  64'(rsp_addr),  64'(0));
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("t6_post_valid", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        tick();
        check_val("t6_post_valid2", 64'(rsp_valid), 64'(0));
        req_valid = 1'b1;
        req_addr  = 'h18;
        tick();
        req_valid = 1'b0;
        expect_rsp("t6_fresh", 'h18, 32'h1000_0006, 1'b0);
        tick();
        check_val("t6_drain", 64'(rsp_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
